// File: rtl/knn_pkg.sv
// Shared constants and types for the KNN query sequencer and its counters.
package knn_pkg;

  localparam int K         = 10;
  localparam int N_CAND    = 64;
  localparam int DRAIN_LAT = 4;

  localparam int IDX_W   = $clog2(K);
  localparam int CAND_W  = $clog2(N_CAND);
  localparam int DRAIN_W = $clog2(DRAIN_LAT) + 1;

  typedef struct packed {
    logic              src;
    logic [CAND_W-1:0] idx;
  } knn_entry_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REPLAY = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_WAIT_K = 3'd4,
    S_COMMIT = 3'd5
  } seq_state_t;

endpackage

// File: rtl/knn_idx_counter.sv
// Index counter with synchronous load, enable and terminal-count flag.
// Wraps exactly at its bound (MAX when counting up, 0 when counting down).
module knn_idx_counter #(
  parameter int             W    = 4,
  parameter logic [W-1:0]   MAX  = '1,
  parameter bit             DOWN = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = DOWN ? (cnt_q == '0) : (cnt_q == MAX);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      if (tc_o) cnt_d = DOWN ? MAX : '0;
      else      cnt_d = DOWN ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/knn_query_sequencer.sv
// Sequences one KNN query: cache replay, candidate stream, drain, top-K wait, commit.
// Optional replay of the previous top-K is enabled with `define PREV_KNN_REPLAY_EN.
//
// state  | meaning
// IDLE   | ready for a query; cache_flush honoured here
// REPLAY | present cached neighbours 0..K-1 to the compare unit
// STREAM | request candidates 0..N_CAND-1 from memory
// DRAIN  | wait for the compare pipeline to empty
// WAIT_K | wait for the sorter to finish
// COMMIT | cache captures top-K, query reported done
module knn_query_sequencer
  import knn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              query_valid,
  output logic              query_ready,
  input  logic              cache_flush,
  output logic [IDX_W-1:0]  cache_rd_idx,
  output logic              cand_req_valid,
  output logic [CAND_W-1:0] cand_req_addr,
  input  logic              cand_req_ready,
  output logic              src_sel,
  output logic              entry_valid,
  output logic              sort_start,
  input  logic              top_k_done,
  output logic              top_k_load,
  output logic              busy,
  output logic              query_done
);

  seq_state_t         state_q;
  logic               sort_start_q;
  logic               accept, cand_hs, cand_load, cand_tc, drain_tc;
  logic               rep_go, rep_tc;
  logic [CAND_W-1:0]  cand_cnt;
  logic [DRAIN_W-1:0] drain_cnt_unused;

  assign accept  = (state_q == S_IDLE) && query_valid;
  assign cand_hs = (state_q == S_STREAM) && cand_req_ready;

`ifdef PREV_KNN_REPLAY_EN
  logic             cache_vld_q;
  logic [IDX_W-1:0] rep_cnt;

  // A flush arriving together with the query already invalidates this replay.
  assign rep_go    = cache_vld_q && !cache_flush;
  assign cand_load = accept || ((state_q == S_REPLAY) && rep_tc);

  knn_idx_counter #(.W(IDX_W), .MAX(IDX_W'(K - 1)), .DOWN(1'b0)) u_rep_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .load_val_i ('0),
    .en_i       (state_q == S_REPLAY),
    .cnt_o      (rep_cnt),
    .tc_o       (rep_tc)
  );

  assign cache_rd_idx = rep_cnt;
`else
  logic unused_flush;
  assign unused_flush = cache_flush;
  assign rep_go       = 1'b0;
  assign rep_tc       = 1'b0;
  assign cand_load    = accept;
  assign cache_rd_idx = '0;
`endif

  knn_idx_counter #(.W(CAND_W), .MAX(CAND_W'(N_CAND - 1)), .DOWN(1'b0)) u_cand_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cand_load),
    .load_val_i ('0),
    .en_i       (cand_hs),
    .cnt_o      (cand_cnt),
    .tc_o       (cand_tc)
  );

  knn_idx_counter #(.W(DRAIN_W), .MAX(DRAIN_W'(DRAIN_LAT - 1)), .DOWN(1'b1)) u_drain_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cand_hs && cand_tc),
    .load_val_i (DRAIN_W'(DRAIN_LAT - 1)),
    .en_i       (state_q == S_DRAIN),
    .cnt_o      (drain_cnt_unused),
    .tc_o       (drain_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sort_start_q <= 1'b0;
`ifdef PREV_KNN_REPLAY_EN
      cache_vld_q  <= 1'b0;
`endif
    end else begin
      sort_start_q <= accept;
      case (state_q)
        S_IDLE: begin
`ifdef PREV_KNN_REPLAY_EN
          if (cache_flush) cache_vld_q <= 1'b0;
`endif
          if (query_valid) state_q <= rep_go ? S_REPLAY : S_STREAM;
        end
        S_REPLAY: if (rep_tc)             state_q <= S_STREAM;
        S_STREAM: if (cand_hs && cand_tc) state_q <= S_DRAIN;
        S_DRAIN:  if (drain_tc)           state_q <= S_WAIT_K;
        S_WAIT_K: if (top_k_done)         state_q <= S_COMMIT;
        S_COMMIT: begin
          state_q <= S_IDLE;
`ifdef PREV_KNN_REPLAY_EN
          cache_vld_q <= 1'b1;
`endif
        end
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign query_ready    = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign sort_start     = sort_start_q;
  assign cand_req_valid = (state_q == S_STREAM);
  assign cand_req_addr  = cand_cnt;
  assign src_sel        = (state_q == S_STREAM);
  assign entry_valid    = (state_q == S_REPLAY) || cand_hs;
  assign top_k_load     = (state_q == S_COMMIT);
  assign query_done     = (state_q == S_COMMIT);

endmodule
